// File: rtl/regfile_multiport.sv
// ============================================================================
// Module      : regfile_multiport
// Description : Multi-port register file. It has NUM_RD combinational read
//               ports and one write port. It adds optional write-to-read
//               bypass, an optional hardwired-zero R0, a post-reset
//               initialisation sweep, and a per-register busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_multiport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_R0    = 1,
    parameter int INIT_MODE  = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         sb_set,
    input  logic [ADDR_WIDTH-1:0]        sb_addr,
    output logic                         init_done
);

    localparam int                    DEPTH       = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic                    r_init_done;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0]        r_busy;

    logic                    w_run;
    logic                    w_wr_ok;
    logic                    w_sb_ok;
    logic [DATA_WIDTH-1:0]   w_init_val;

    assign w_run      = (r_state == ST_RUN);
    // Writes and scoreboard sets aimed at a hardwired-zero R0 are discarded here.
    assign w_wr_ok    = w_run && wr_en  && !((ZERO_R0 != 0) && (wr_addr == '0));
    assign w_sb_ok    = w_run && sb_set && !((ZERO_R0 != 0) && (sb_addr == '0));
    assign w_init_val = (INIT_MODE != 0) ? DATA_WIDTH'(r_cnt) : '0;
    assign init_done  = r_init_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_busy      <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST_ADDR) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // The set is ordered after the clear, so a set wins on the same address.
                    if (w_wr_ok) r_busy[wr_addr] <= 1'b0;
                    if (w_sb_ok) r_busy[sb_addr] <= 1'b1;
                end
                default: begin
                    r_state     <= ST_INIT;
                    r_cnt       <= '0;
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (r_state == ST_INIT) begin
                r_mem[r_cnt] <= w_init_val;
            end else if (w_wr_ok) begin
                r_mem[wr_addr] <= wr_data;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_addr;
        logic                  w_zero;
        logic                  w_fwd;
        logic [DATA_WIDTH-1:0] w_data;

        assign w_addr = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_zero = (ZERO_R0 != 0) && (w_addr == '0);
        assign w_fwd  = (BYPASS != 0) && w_wr_ok && (wr_addr == w_addr);
        assign w_data = (!w_run || w_zero) ? '0 :
                        w_fwd              ? wr_data : r_mem[w_addr];

        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w_data;
        // A bypassed write hands the consumer its data now, so the register is no longer busy.
        assign rd_busy[k] = w_run && !w_fwd && r_busy[w_addr];
    end

endmodule

`default_nettype wire

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the single-CPU register file.
- Provides DEPTH x DATA_WIDTH storage with NUM_RD combinational read ports and one write port.
- Adds optional write-to-read bypass, an optional hardwired-zero R0, a sequential post-reset initialisation sweep, and a per-register busy scoreboard for multi-cycle producers.
- Sits between decode (read addresses, issue) and writeback in the CPU datapath.

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 5, register address bits; DEPTH = 2**ADDR_WIDTH (derived, not overridable).
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports.
- ZERO_R0, 1, 1 = register 0 reads as 0, writes to it are dropped, and its busy bit is never set.
- INIT_MODE, 1, 0 = initialise every register to 0; 1 = initialise reg[i] = i (zero-extended).

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rd_addr  input  NUM_RD*ADDR_WIDTH  packed read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  output  NUM_RD*DATA_WIDTH  packed read data, combinational.
- rd_busy  output  NUM_RD  scoreboard busy flag for each read address, combinational.
- wr_en  input  1  write enable.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- sb_set  input  1  marks sb_addr busy (a producer has issued).
- sb_addr  input  ADDR_WIDTH  scoreboard set address.
- init_done  output  1  high once the initialisation sweep has completed.

Behaviour:
- Decided: one clock; reset is synchronous and active-high. Ports are named clock and reset.
- State machine has two states, INIT and RUN.
  - Reset (sampled high at a rising edge) forces INIT, init counter = 0, all busy bits = 0, init_done = 0. This takes priority over every other input.
- INIT:
  - Each cycle writes reg[cnt] = (INIT_MODE ? cnt : 0), then cnt++.
  - After the write of DEPTH-1, the next state is RUN and init_done = 1.
  - Sweep length is exactly DEPTH cycles after reset deasserts (32 at defaults).
  - wr_en and sb_set are ignored; all rd_data = 0 and all rd_busy = 0.
  - Reset asserted mid-sweep restarts the sweep at cnt = 0.
- RUN write: when wr_en is high, reg[wr_addr] <= wr_data at the rising edge.
  - If ZERO_R0 and wr_addr == 0, the write is dropped.
  - No negedge writes.
- Read, per port k:
  - ZERO_R0 and addr == 0 -> 0.
  - Else BYPASS and wr_en and wr_addr == addr (and the write is not dropped) -> wr_data.
  - Else reg[addr].
  - BYPASS = 0 returns the old value in the write cycle and the new value the following cycle.
- Scoreboard: busy[DEPTH] register.
  - wr_en clears busy[wr_addr].
  - sb_set sets busy[sb_addr]; ignored for address 0 when ZERO_R0.
  - Set and clear of the same address in the same cycle: set wins, so busy = 1.
  - Set and clear of different addresses: both take effect.
  - rd_busy[k] = busy[addr_k], forced 0 when BYPASS and a same-cycle non-dropped write targets addr_k (consumer may take the bypassed data).
- Multiple read ports may use the same address; each returns identical data.
- No X on any output after reset: outputs are defined from the first cycle reset is high.

Test Plan:
- Reset 1 cycle, then idle 32 cycles with rd_addr0 = 7 -> init_done rises exactly on cycle 32; rd_data0 = 0 before that, then 0x00000007 (INIT_MODE = 1).
- RUN: write reg5 = 0xDEADBEEF with rd_addr0 = 5, BYPASS = 1 -> rd_data0 = 0xDEADBEEF in the write cycle. Same test with BYPASS = 0 -> 0x00000005 in the write cycle, 0xDEADBEEF on the next cycle.
- Write reg0 = 0xFFFFFFFF, then sb_set with sb_addr = 0 -> rd_data for addr 0 = 0 and rd_busy = 0 (ZERO_R0 = 1).
- sb_set on 3, then idle 2 cycles -> rd_busy for addr 3 = 1.
  - Then sb_set 3 together with wr_en wr_addr = 3 -> busy stays 1.
  - Then wr_en only on 3 -> rd_busy = 0 in that cycle (bypass) and the cycle after.
- Reset asserted at sweep cycle 10 with wr_en pulses during INIT -> sweep restarts and init_done rises 32 cycles after release; the INIT-time write values never appear on reads.
- NUM_RD = 4, all ports reading 9 while writing 0x12345678 to reg9 -> all four rd_data = 0x12345678.
